// File: rtl/id_ex_stage_if.sv
// Decode/Execute boundary bundle for id_ex_stage: D-side fields, resolved branch,
// registered E-side fields and hazard control outputs.
interface id_ex_stage_if #(
    parameter int XLEN = 32
);
    logic            valid_D;
    logic [XLEN-1:0] pc_D;
    logic [4:0]      rs1_D, rs2_D, rd_D;
    logic [XLEN-1:0] rd1_D, rd2_D, imm_D;
    logic [3:0]      alu_ctrl_D;
    logic            alu_src_D, reg_we_D, mem_we_D, branch_D, jump_D;
    logic [1:0]      result_src_D;
    logic            pc_src_E;

    logic            valid_E;
    logic [XLEN-1:0] pc_E;
    logic [4:0]      rs1_E, rs2_E, rd_E;
    logic [XLEN-1:0] rd1_E, rd2_E, imm_E;
    logic [3:0]      alu_ctrl_E;
    logic            alu_src_E, reg_we_E, mem_we_E, branch_E, jump_E;
    logic [1:0]      result_src_E;
    logic            stall_F, stall_D, flush_D, flush_E;

    modport master (
        output valid_D, pc_D, rs1_D, rs2_D, rd_D, rd1_D, rd2_D, imm_D, alu_ctrl_D,
               alu_src_D, reg_we_D, mem_we_D, branch_D, jump_D, result_src_D, pc_src_E,
        input  valid_E, pc_E, rs1_E, rs2_E, rd_E, rd1_E, rd2_E, imm_E, alu_ctrl_E,
               alu_src_E, reg_we_E, mem_we_E, branch_E, jump_E, result_src_E,
               stall_F, stall_D, flush_D, flush_E
    );

    modport slave (
        input  valid_D, pc_D, rs1_D, rs2_D, rd_D, rd1_D, rd2_D, imm_D, alu_ctrl_D,
               alu_src_D, reg_we_D, mem_we_D, branch_D, jump_D, result_src_D, pc_src_E,
        output valid_E, pc_E, rs1_E, rs2_E, rd_E, rd1_E, rd2_E, imm_E, alu_ctrl_E,
               alu_src_E, reg_we_E, mem_we_E, branch_E, jump_E, result_src_E,
               stall_F, stall_D, flush_D, flush_E
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and branch flush control.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    id_ex_stage_if.slave     bus
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [CNT_W-1:0] bubble_cnt
`endif
);
    logic            r_valid;
    logic [XLEN-1:0] r_pc, r_rd1, r_rd2, r_imm;
    logic [4:0]      r_rs1, r_rs2, r_rd;
    logic [3:0]      r_alu_ctrl;
    logic            r_alu_src, r_reg_we, r_mem_we, r_branch, r_jump;
    logic [1:0]      r_result_src;

    logic w_lwstall;
    logic w_bubble;

    // Conservative: both source specifiers are compared whether or not the op reads them.
    assign w_lwstall = bus.valid_D & r_valid & r_reg_we & (r_result_src == 2'b01) &
                       (r_rd != 5'd0) & ((r_rd == bus.rs1_D) | (r_rd == bus.rs2_D));
    assign w_bubble  = reset & (w_lwstall | bus.pc_src_E);

    assign bus.stall_F = reset & w_lwstall & ~bus.pc_src_E;
    assign bus.stall_D = reset & w_lwstall & ~bus.pc_src_E;
    assign bus.flush_D = reset & bus.pc_src_E;
    assign bus.flush_E = w_bubble;

    always_ff @(posedge clk) begin
        if (!reset || w_bubble) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_rd1        <= '0;
            r_rd2        <= '0;
            r_imm        <= '0;
            r_alu_ctrl   <= '0;
            r_alu_src    <= 1'b0;
            r_reg_we     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_branch     <= 1'b0;
            r_jump       <= 1'b0;
            r_result_src <= '0;
        end else begin
            r_valid      <= bus.valid_D;
            r_pc         <= bus.pc_D;
            r_rs1        <= bus.rs1_D;
            r_rs2        <= bus.rs2_D;
            r_rd         <= bus.rd_D;
            r_rd1        <= bus.rd1_D;
            r_rd2        <= bus.rd2_D;
            r_imm        <= bus.imm_D;
            r_alu_ctrl   <= bus.alu_ctrl_D;
            r_alu_src    <= bus.alu_src_D;
            r_reg_we     <= bus.reg_we_D;
            r_mem_we     <= bus.mem_we_D;
            r_branch     <= bus.branch_D;
            r_jump       <= bus.jump_D;
            r_result_src <= bus.result_src_D;
        end
    end

    assign bus.valid_E      = r_valid;
    assign bus.pc_E         = r_pc;
    assign bus.rs1_E        = r_rs1;
    assign bus.rs2_E        = r_rs2;
    assign bus.rd_E         = r_rd;
    assign bus.rd1_E        = r_rd1;
    assign bus.rd2_E        = r_rd2;
    assign bus.imm_E        = r_imm;
    assign bus.alu_ctrl_E   = r_alu_ctrl;
    assign bus.alu_src_E    = r_alu_src;
    assign bus.reg_we_E     = r_reg_we;
    assign bus.mem_we_E     = r_mem_we;
    assign bus.branch_E     = r_branch;
    assign bus.jump_E       = r_jump;
    assign bus.result_src_E = r_result_src;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [CNT_W-1:0] r_bubble_cnt;

    // Wraps naturally from all-ones to zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
`else
    localparam int unused_cnt_w = CNT_W;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected E contents queued at drive time,
// popped and compared one edge later; hazard outputs checked inline per test.
module tb_id_ex_stage;
`ifdef ID_EX_BUBBLE_CNT_EN
    localparam int TB_CNT_W = 4;
`else
    localparam int TB_CNT_W = 32;
`endif

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rd1, rd2, imm;
        logic [3:0]  alu_ctrl;
        logic        alu_src, reg_we, mem_we, branch, jump;
        logic [1:0]  result_src;
    } e_t;

    typedef struct packed {
        e_t                  e;
        logic [TB_CNT_W-1:0] cnt;
    } sb_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    sb_t  sb_q[$];
    logic [TB_CNT_W-1:0] exp_cnt = '0;
    logic [3:0] haz;

    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(32)) bus ();

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [TB_CNT_W-1:0] bubble_cnt;
    id_ex_stage #(.XLEN(32), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .reset(reset), .bus(bus), .bubble_cnt(bubble_cnt));
`else
    id_ex_stage #(.XLEN(32), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .reset(reset), .bus(bus));
`endif

    assign haz = {bus.stall_F, bus.stall_D, bus.flush_D, bus.flush_E};

    function automatic e_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic we, input logic [1:0] rsrc);
        e_t e;
        e.valid      = v;
        e.pc         = $urandom & 32'hFFFF_FFFC;
        e.rs1        = rs1;
        e.rs2        = rs2;
        e.rd         = rd;
        e.rd1        = $urandom;
        e.rd2        = $urandom;
        e.imm        = $urandom;
        e.alu_ctrl   = 4'($urandom);
        e.alu_src    = 1'($urandom);
        e.reg_we     = we;
        e.mem_we     = 1'($urandom);
        e.branch     = 1'($urandom);
        e.jump       = 1'($urandom);
        e.result_src = rsrc;
        return e;
    endfunction

    // Drives one D-side transaction at the falling edge and queues the E contents
    // the next rising edge must produce; bubble says whether this cycle flushes E.
    task automatic drive(input e_t d, input logic rst, input logic pc_src, input logic bubble);
        sb_t s;
        @(negedge clk);
        reset            = rst;
        bus.valid_D      = d.valid;
        bus.pc_D         = d.pc;
        bus.rs1_D        = d.rs1;
        bus.rs2_D        = d.rs2;
        bus.rd_D         = d.rd;
        bus.rd1_D        = d.rd1;
        bus.rd2_D        = d.rd2;
        bus.imm_D        = d.imm;
        bus.alu_ctrl_D   = d.alu_ctrl;
        bus.alu_src_D    = d.alu_src;
        bus.reg_we_D     = d.reg_we;
        bus.mem_we_D     = d.mem_we;
        bus.branch_D     = d.branch;
        bus.jump_D       = d.jump;
        bus.result_src_D = d.result_src;
        bus.pc_src_E     = pc_src;
        if (!rst) exp_cnt = '0;
        else if (bubble) exp_cnt = exp_cnt + 1'b1;
        s.e   = (!rst || bubble) ? e_t'(0) : d;
        s.cnt = exp_cnt;
        sb_q.push_back(s);
        #1;
    endtask

    // E-side monitor: every rising edge consumes one queued expectation.
    always begin
        sb_t s;
        e_t  got;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            got = {bus.valid_E, bus.pc_E, bus.rs1_E, bus.rs2_E, bus.rd_E, bus.rd1_E, bus.rd2_E,
                   bus.imm_E, bus.alu_ctrl_E, bus.alu_src_E, bus.reg_we_E, bus.mem_we_E,
                   bus.branch_E, bus.jump_E, bus.result_src_E};
            n_tests++;
            if (got !== s.e) begin
                n_fail++;
                $display("FAIL e_fields got=%h exp=%h", got, s.e);
            end else
                $display("[TB] E ok valid=%0b pc=%h rd=%0d we=%0b", got.valid, got.pc, got.rd, got.reg_we);
`ifdef ID_EX_BUBBLE_CNT_EN
            n_tests++;
            if (bubble_cnt !== s.cnt) begin
                n_fail++;
                $display("FAIL bubble_cnt got=%0d exp=%0d", bubble_cnt, s.cnt);
            end
`endif
        end
    end

    task automatic test_reset();
        e_t d;
        d = '1;
        drive(d, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (haz !== 4'b0000) begin n_fail++; $display("FAIL reset_hazard1 got=%b exp=0000", haz); end
        drive(d, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (haz !== 4'b0000) begin n_fail++; $display("FAIL reset_hazard2 got=%b exp=0000", haz); end
    endtask

    task automatic test_pass_through();
        e_t d;
        d = mk(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 2'b00);
        d.pc  = 32'h100;
        d.imm = 32'hFFFF_FFF0;
        drive(d, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (haz !== 4'b0000) begin n_fail++; $display("FAIL pass_hazard got=%b exp=0000", haz); end
    endtask

    task automatic test_load_use();
        e_t lw, add;
        lw  = mk(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 2'b01);
        add = mk(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 2'b00);
        drive(lw, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (haz !== 4'b0000) begin n_fail++; $display("FAIL lu_enter got=%b exp=0000", haz); end
        drive(add, 1'b1, 1'b0, 1'b1);
        n_tests++;
        if (haz !== 4'b1101) begin n_fail++; $display("FAIL lu_stall got=%b exp=1101", haz); end
        drive(add, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (haz !== 4'b0000) begin n_fail++; $display("FAIL lu_release got=%b exp=0000", haz); end
    endtask

    task automatic test_x0_load();
        e_t lw0, use0;
        lw0  = mk(1'b1, 5'd3, 5'd4, 5'd0, 1'b1, 2'b01);
        use0 = mk(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 2'b00);
        drive(lw0, 1'b1, 1'b0, 1'b0);
        drive(use0, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (haz !== 4'b0000) begin n_fail++; $display("FAIL x0_load got=%b exp=0000", haz); end
    endtask

    task automatic test_back_to_back();
        e_t lw5, lw6, add7;
        lw5  = mk(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 2'b01);
        lw6  = mk(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 2'b01);
        add7 = mk(1'b1, 5'd6, 5'd6, 5'd7, 1'b1, 2'b00);
        drive(lw5, 1'b1, 1'b0, 1'b0);
        drive(lw6, 1'b1, 1'b0, 1'b1);
        n_tests++;
        if (haz !== 4'b1101) begin n_fail++; $display("FAIL b2b_stall1 got=%b exp=1101", haz); end
        drive(lw6, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (haz !== 4'b0000) begin n_fail++; $display("FAIL b2b_rel1 got=%b exp=0000", haz); end
        drive(add7, 1'b1, 1'b0, 1'b1);
        n_tests++;
        if (haz !== 4'b1101) begin n_fail++; $display("FAIL b2b_stall2 got=%b exp=1101", haz); end
        drive(add7, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (haz !== 4'b0000) begin n_fail++; $display("FAIL b2b_rel2 got=%b exp=0000", haz); end
    endtask

    task automatic test_branch_flush();
        e_t d, lw, add;
        d   = mk(1'b1, 5'd2, 5'd3, 5'd9, 1'b1, 2'b10);
        lw  = mk(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 2'b01);
        add = mk(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 2'b00);
        drive(d, 1'b1, 1'b1, 1'b1);
        n_tests++;
        if (haz !== 4'b0011) begin n_fail++; $display("FAIL br_flush got=%b exp=0011", haz); end
        drive(lw, 1'b1, 1'b0, 1'b0);
        drive(add, 1'b1, 1'b1, 1'b1);
        n_tests++;
        if (haz !== 4'b0011) begin n_fail++; $display("FAIL br_over_lw got=%b exp=0011", haz); end
    endtask

    task automatic test_reset_mid();
        e_t lw, add;
        lw  = mk(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 2'b01);
        add = mk(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 2'b00);
        drive(lw, 1'b1, 1'b0, 1'b0);
        drive(add, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (haz !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_haz got=%b exp=0000", haz); end
        drive(add, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (haz !== 4'b0000) begin n_fail++; $display("FAIL post_reset_haz got=%b exp=0000", haz); end
    endtask

    task automatic test_counter_wrap();
        logic [TB_CNT_W-1:0] start;
        e_t d;
        start = exp_cnt;
        for (int i = 0; i < 16; i++) begin
            d = mk(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 2'b00);
            drive(d, 1'b1, 1'b1, 1'b1);
        end
        @(posedge clk);
        #2;
`ifdef ID_EX_BUBBLE_CNT_EN
        n_tests++;
        if (bubble_cnt !== start) begin
            n_fail++;
            $display("FAIL cnt_wrap got=%0d exp=%0d", bubble_cnt, start);
        end
`else
        n_tests++;
        if (bus.valid_E !== 1'b0) begin n_fail++; $display("FAIL wrap_bubble got=%b exp=0", bus.valid_E); end
`endif
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_load_use();
        test_x0_load();
        test_back_to_back();
        test_branch_flush();
        test_reset_mid();
        test_counter_wrap();
        @(posedge clk);
        #2;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got=%0d exp=0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline boundary of the 5-stage RV32I core: registers the decoded instruction fields from Decode into Execute, and owns load-use hazard detection and branch flush control. Its registered `rs1_E`, `rs2_E`, `rd_E` and control outputs feed the execute-stage forwarding logic and ALU. Its `stall_F`, `stall_D`, `flush_D` outputs steer the IF/ID register and PC.

## Interface
Parameters:
- `XLEN`, 32, datapath width (pc, operands, immediate).
- `CNT_W`, 32, bubble counter width (only with `ID_EX_BUBBLE_CNT_EN`).

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - `clk`  in  1  core clock; all state updates on rising edge.
  - `reset`  in  1  synchronous, active-low reset.
- Decode-side inputs:
  - `valid_D`  in  1  Decode holds a real instruction.
  - `pc_D`  in  XLEN  instruction PC.
  - `rs1_D`, `rs2_D`, `rd_D`  in  5 each  register specifiers.
  - `rd1_D`, `rd2_D`  in  XLEN each  register-file read data.
  - `imm_D`  in  XLEN  sign-extended immediate.
  - `alu_ctrl_D`  in  4  ALU operation.
  - `alu_src_D`  in  1  1 = immediate operand B.
  - `reg_we_D`, `mem_we_D`, `branch_D`, `jump_D`  in  1 each  control bits.
  - `result_src_D`  in  2  00 ALU, 01 load, 10 pc+4.
- Execute-side input:
  - `pc_src_E`  in  1  taken branch/jump resolved in Execute.
- Execute-side outputs:
  - `valid_E`, `pc_E`, `rs1_E`, `rs2_E`, `rd_E`, `rd1_E`, `rd2_E`, `imm_E`, `alu_ctrl_E`, `alu_src_E`, `reg_we_E`, `mem_we_E`, `branch_E`, `jump_E`, `result_src_E`  out  widths as D counterparts  registered Execute fields.
- Hazard control outputs:
  - `stall_F`, `stall_D`  out  1 each  hold PC / IF-ID register.
  - `flush_D`  out  1  clear IF/ID register.
  - `flush_E`  out  1  internal bubble insert, exported for trace.
- `bubble_cnt`  out  CNT_W  bubbles inserted (only with `ID_EX_BUBBLE_CNT_EN`).

## Operation
- `lwstall` = `valid_D & valid_E & reg_we_E & (result_src_E==2'b01) & (rd_E!=0) & ((rd_E==rs1_D) | (rd_E==rs2_D))`.
- `stall_F = stall_D = lwstall & ~pc_src_E`.
- `flush_D = pc_src_E`.
- `flush_E = lwstall | pc_src_E`.
- All four hazard outputs are forced to 0 while `reset==0`.
- Register update each rising edge, in priority order:
  1. `reset==0`: every E output cleared to 0.
  2. `flush_E==1`: bubble loaded. `valid_E`, `reg_we_E`, `mem_we_E`, `branch_E`, `jump_E`, `result_src_E`, `rs1_E`, `rs2_E` and `rd_E` go to 0. Data fields (`pc_E`, `rd1_E`, `rd2_E`, `imm_E`, `alu_ctrl_E`, `alu_src_E`) are also cleared to 0 for determinism.
  3. Otherwise: every E field captures its D counterpart.
- The stage itself never holds: a load-use stall freezes F/D and inserts exactly one bubble into E.
- A bubble must never trigger forwarding or a write: `rd_E=0` and `reg_we_E=0` guarantee this.
- `rs1_D`/`rs2_D` matching `rd_E` is checked regardless of whether the instruction actually reads that operand (conservative stall, accepted).

## Timing
- D→E latency: 1 cycle.
- Hazard outputs are combinational from registered E state plus current D inputs: same-cycle, no added latency.
- Load-use stall lasts exactly 1 cycle. Next cycle the load is in M, `lwstall` drops, and the forwarding path supplies the value.
- Back-to-back dependent loads (`lw x5`; `lw x6,0(x5)`; `add x7,x6,x6`) produce two separate 1-cycle stalls.
- `lwstall` and `pc_src_E` cannot be true together architecturally. If both are forced high anyway: flush wins, the stalls are suppressed, and both D and E are flushed.
- Reset mid-operation: the next edge clears E regardless of pending flush/stall. Hazard outputs are 0 during the reset cycle.
- Reset values: all outputs 0.

## Configuration
- `ID_EX_BUBBLE_CNT_EN` defined:
  - `bubble_cnt` port and a CNT_W-bit counter are present.
  - The counter increments on every edge where `reset==1 & flush_E==1`.
  - It wraps from all-ones to 0 and is cleared by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset: hold `reset=0` 2 cycles with all D inputs nonzero → every E output 0, hazard outputs 0, `bubble_cnt=0`.
- Pass-through: `valid_D=1`, `pc_D=0x100`, `rd_D=5`, `reg_we_D=1`, `imm_D=0xFFFFFFF0` → next cycle `pc_E=0x100`, `rd_E=5`, `reg_we_E=1`, `imm_E=0xFFFFFFF0`, no stall.
- Load-use: `lw x5` in E with `add x6,x5,x1` in D:
  - Same cycle: `stall_F=stall_D=flush_E=1`.
  - Next cycle: `valid_E=0`, `rd_E=0`, `bubble_cnt=1`.
  - Cycle after: the add enters E, stalls are 0.
- x0 load: `lw x0` in E with `rs1_D=0` → no stall.
- Branch flush: `pc_src_E=1` → `flush_D=1`, `flush_E=1`, `stall_D=0`; next cycle E holds a bubble, `bubble_cnt` +1. With `lwstall` also forced high: stalls stay 0.
- Counter wrap (CNT_W=4): 16 flushes → `bubble_cnt` returns to 0.
